// File: rtl/quadrature_encoder.sv
// rtl/quadrature_encoder.sv - quadrature A/B generator driven by step commands
//
// Accepts one command at a time (direction, edge count, edge spacing) and emits
// that many quadrature edges on A/B, one phase bit toggling per edge, while
// tracking a signed, wrapping edge position.
//
// Ports:
//   CLOCK       system clock, rising edge
//   RESET       asynchronous, active-high reset
//   CMD_VALID   command request
//   CMD_READY   block can accept a command
//   CMD_DIR     1 = count up, 0 = count down
//   CMD_STEPS   number of edges to emit
//   CMD_PERIOD  clocks between edges (0 is treated as 1)
//   ABORT       terminate the active command
//   A, B        registered quadrature phases
//   BUSY        command in progress
//   DONE        one-cycle completion pulse
//   POSITION    signed running edge count, wraps modulo 2^POS_W
//   INDEX       once-per-revolution marker
//
// Build option: QUAD_ENC_INDEX_EN enables the revolution counter behind INDEX;
// without it INDEX is tied to 0.

module quadrature_encoder #(
    parameter int STEP_W       = 16,
    parameter int PER_W        = 16,
    parameter int POS_W        = 16,
    parameter int INDEX_CLICKS = 24
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_DIR,
    input  logic [STEP_W-1:0] CMD_STEPS,
    input  logic [PER_W-1:0]  CMD_PERIOD,
    input  logic              ABORT,
    output logic              A,
    output logic              B,
    output logic              BUSY,
    output logic              DONE,
    output logic [POS_W-1:0]  POSITION,
    output logic              INDEX
);

    if (INDEX_CLICKS < 1) begin : g_bad_index_clicks
        $error("INDEX_CLICKS must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [PER_W-1:0]  PER_ONE  = PER_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);

    state_t             state_q, state_d;
    logic               dir_q, dir_d;
    logic [STEP_W-1:0]  remaining_q, remaining_d;
    logic [PER_W-1:0]   period_q, period_d;
    logic [PER_W-1:0]   timer_q, timer_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;
    logic               step;

    assign accept = CMD_VALID && ready_q && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        remaining_d = remaining_q;
        period_d    = period_q;
        timer_d     = timer_q;
        a_d         = a_q;
        b_d         = b_q;
        pos_d       = pos_q;
        done_d      = 1'b0;
        step        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dir_d       = CMD_DIR;
                    period_d    = (CMD_PERIOD == '0) ? PER_ONE : CMD_PERIOD;
                    remaining_d = CMD_STEPS;
                    timer_d     = (CMD_PERIOD == '0) ? PER_ONE : CMD_PERIOD;
                    state_d     = (CMD_STEPS == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                // ABORT takes priority over an edge that falls due this cycle.
                if (ABORT) begin
                    state_d = ST_FINISH;
                end else if (timer_q == PER_ONE) begin
                    step        = 1'b1;
                    timer_d     = period_q;
                    remaining_d = remaining_q - STEP_ONE;
                    if (remaining_q == STEP_ONE) begin
                        state_d = ST_FINISH;
                    end
                end else begin
                    timer_d = timer_q - PER_ONE;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Gray stepping: up is 00->10->11->01, down is the reverse.
        // Each rule toggles exactly one of the two phase bits.
        if (step) begin
            if (dir_q) begin
                a_d   = ~b_q;
                b_d   = a_q;
                pos_d = pos_q + POS_ONE;
            end else begin
                a_d   = b_q;
                b_d   = ~a_q;
                pos_d = pos_q - POS_ONE;
            end
        end

        // READY follows IDLE one cycle late, so the cycle DONE is high is
        // still not ready; it drops immediately on an accept.
        ready_d = (state_q == ST_IDLE) && !accept;
        busy_d  = (state_d == ST_RUN);
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            remaining_q <= '0;
            period_q    <= PER_ONE;
            timer_q     <= PER_ONE;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            pos_q       <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            remaining_q <= remaining_d;
            period_q    <= period_d;
            timer_q     <= timer_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pos_q       <= pos_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef QUAD_ENC_INDEX_EN
    localparam int REV_N = 4 * INDEX_CLICKS;
    localparam int REV_W = (REV_N > 1) ? $clog2(REV_N) : 1;
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(REV_N - 1);
    localparam logic [REV_W-1:0] REV_ONE = REV_W'(1);

    logic [REV_W-1:0] rev_q, rev_d;
    logic             index_q, index_d;

    always_comb begin
        rev_d = rev_q;
        if (step) begin
            if (dir_q) begin
                rev_d = (rev_q == REV_MAX) ? '0 : rev_q + REV_ONE;
            end else begin
                rev_d = (rev_q == '0) ? REV_MAX : rev_q - REV_ONE;
            end
        end
        index_d = (rev_d == '0) && !a_d && !b_d;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            rev_q   <= '0;
            index_q <= 1'b0;
        end else begin
            rev_q   <= rev_d;
            index_q <= index_d;
        end
    end

    assign INDEX = index_q;
`else
    assign INDEX = 1'b0;
`endif

    assign CMD_READY = ready_q;
    assign A         = a_q;
    assign B         = b_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign POSITION  = pos_q;

endmodule

// File: tb/tb_quadrature_encoder.sv
// tb/tb_quadrature_encoder.sv - self-checking bench for quadrature_encoder

module tb_quadrature_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [15:0] cmd_period = '0;
    logic        abort_in = 1'b0;
    logic        a_out, b_out, busy, done, index_out;
    logic [15:0] position;

    int tests = 0;
    int fails = 0;

    // Independent loopback decoder: up when new A differs from previous B.
    int   dec_edges = 0;
    int   dec_glitches = 0;
    logic dec_pa = 1'b0;
    logic dec_pb = 1'b0;

    typedef struct {
        logic        a;
        logic        b;
        logic        busy;
        logic        done;
        logic        ready;
        logic [15:0] pos;
    } vec_t;

    vec_t tbl[$];

    quadrature_encoder #(
        .STEP_W(16), .PER_W(16), .POS_W(16), .INDEX_CLICKS(24)
    ) dut (
        .CLOCK(clk), .RESET(rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_DIR(cmd_dir), .CMD_STEPS(cmd_steps), .CMD_PERIOD(cmd_period),
        .ABORT(abort_in),
        .A(a_out), .B(b_out), .BUSY(busy), .DONE(done),
        .POSITION(position), .INDEX(index_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            dec_edges    = 0;
            dec_glitches = 0;
            dec_pa       = 1'b0;
            dec_pb       = 1'b0;
        end else if (a_out !== dec_pa || b_out !== dec_pb) begin
            if (a_out !== dec_pa && b_out !== dec_pb) dec_glitches++;
            else if (a_out !== dec_pb) dec_edges++;
            else dec_edges--;
            dec_pa = a_out;
            dec_pb = b_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic a, input logic b, input logic bz, input logic dn,
                       input logic rdy, input logic [15:0] pos);
        vec_t v;
        v.a = a; v.b = b; v.busy = bz; v.done = dn; v.ready = rdy; v.pos = pos;
        tbl.push_back(v);
    endtask

    // Compares table rows first..last on successive negedges, starting now.
    task automatic run_vecs(input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (i > first) @(negedge clk);
            chk($sformatf("%s_k%0d", tag, i - first),
                {11'd0, a_out, b_out, busy, done, cmd_ready, position},
                {11'd0, tbl[i].a, tbl[i].b, tbl[i].busy, tbl[i].done, tbl[i].ready, tbl[i].pos});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b0;
        abort_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Returns at the negedge just after the accepting clock edge.
    task automatic send(input logic dir, input logic [15:0] steps, input logic [15:0] per,
                        input bit hold);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir = dir;
        cmd_steps = steps;
        cmd_period = per;
        @(posedge clk);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        // Test 1: up, 4 steps, period 3 (rows 0..14)
        add(0,0,1,0,0,16'd0); add(0,0,1,0,0,16'd0); add(0,0,1,0,0,16'd0);
        add(1,0,1,0,0,16'd1); add(1,0,1,0,0,16'd1); add(1,0,1,0,0,16'd1);
        add(1,1,1,0,0,16'd2); add(1,1,1,0,0,16'd2); add(1,1,1,0,0,16'd2);
        add(0,1,1,0,0,16'd3); add(0,1,1,0,0,16'd3); add(0,1,1,0,0,16'd3);
        add(0,0,0,0,0,16'd4); add(0,0,0,1,0,16'd4); add(0,0,0,0,1,16'd4);
        // Test 2: down, 2 steps, period 0 clamped to 1 (rows 15..19)
        add(0,0,1,0,0,16'h0000); add(0,1,1,0,0,16'hFFFF); add(1,1,0,0,0,16'hFFFE);
        add(1,1,0,1,0,16'hFFFE); add(1,1,0,0,1,16'hFFFE);
        // Test 3: zero steps, period 5 (rows 20..22)
        add(1,1,0,0,0,16'hFFFE); add(1,1,0,1,0,16'hFFFE); add(1,1,0,0,1,16'hFFFE);

        // Reset state while reset is held
        repeat (2) @(negedge clk);
        chk("reset_state", {25'd0, a_out, b_out, busy, done, cmd_ready, index_out, (position == 16'd0)},
            {25'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        rst = 1'b0;
        @(negedge clk);
`ifdef QUAD_ENC_INDEX_EN
        chk("index_after_reset", {31'd0, index_out}, 32'd1);
`else
        chk("index_after_reset", {31'd0, index_out}, 32'd0);
`endif

        send(1'b1, 16'd4, 16'd3, 1'b0);
        run_vecs("t1", 0, 14);

        do_reset();
        send(1'b0, 16'd2, 16'd0, 1'b0);
        run_vecs("t2", 15, 19);
        send(1'b1, 16'd0, 16'd5, 1'b0);
        run_vecs("t3", 20, 22);
        repeat (6) @(negedge clk);
        chk("t3_hold", {14'd0, a_out, b_out, position}, {14'd0, 1'b1, 1'b1, 16'hFFFE});

        // ABORT while idle is ignored
        abort_in = 1'b1;
        repeat (3) @(negedge clk);
        abort_in = 1'b0;
        chk("abort_idle", {29'd0, busy, done, cmd_ready}, {29'd0, 1'b0, 1'b0, 1'b1});

        // Abort on the clock the 3rd edge is due, CMD_VALID held through RUN
        do_reset();
        send(1'b1, 16'd100, 16'd4, 1'b1);
        repeat (11) @(negedge clk);
        chk("abort_pre", {13'd0, a_out, b_out, cmd_ready, position},
            {13'd0, 1'b1, 1'b1, 1'b0, 16'd2});
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        chk("abort_k12", {11'd0, a_out, b_out, busy, done, cmd_ready, position},
            {11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2});
        @(negedge clk);
        chk("abort_done", {30'd0, done, cmd_ready}, {30'd0, 1'b1, 1'b0});
        @(negedge clk);
        chk("abort_ready", {30'd0, done, cmd_ready}, {30'd0, 1'b0, 1'b1});
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_after", {13'd0, a_out, b_out, busy, position},
            {13'd0, 1'b1, 1'b1, 1'b0, 16'd2});
`ifndef QUAD_ENC_INDEX_EN
        chk("index_tied_low", {31'd0, index_out}, 32'd0);
`endif

`ifdef QUAD_ENC_INDEX_EN
        begin
            int bad;
            do_reset();
            chk("idx_start", {31'd0, index_out}, 32'd1);
            send(1'b1, 16'd96, 16'd1, 1'b0);
            bad = 0;
            for (int k = 1; k <= 96; k++) begin
                @(negedge clk);
                if (index_out !== (k == 96)) bad++;
            end
            chk("idx_up_errors", bad, 32'd0);
            wait_done("idx_up_done", 10);
            @(negedge clk);
            send(1'b0, 16'd96, 16'd1, 1'b0);
            bad = 0;
            for (int k = 1; k <= 96; k++) begin
                @(negedge clk);
                if (index_out !== (k == 96)) bad++;
            end
            chk("idx_dn_errors", bad, 32'd0);
            wait_done("idx_dn_done", 10);
        end
`endif

        // Loopback into the reference decoder
        do_reset();
        send(1'b1, 16'd40, 16'd8, 1'b0);
        wait_done("loop_up_done", 1000);
        chk("loop_up_count", dec_edges / 4, 32'd10);
        chk("loop_up_pos", {16'd0, position}, 32'd40);
        send(1'b0, 16'd40, 16'd8, 1'b0);
        wait_done("loop_dn_done", 1000);
        chk("loop_dn_count", dec_edges / 4, 32'd0);
        chk("loop_dn_pos", {16'd0, position}, 32'd0);
        chk("loop_one_bit_per_edge", dec_glitches, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/quadrature_encoder.md
Name: quadrature_encoder

Overview:
- Generates two-phase quadrature signals A/B from step commands. It is the transmit-side counterpart of the team's quadrature decoder.
- Used to emulate a rotary encoder for bench and on-board loopback into the decoder, and to drive downstream quadrature inputs.
- Each accepted command emits a programmed number of edges in one direction at a programmed edge spacing, and tracks absolute position.

Parameters:
- STEP_W, 16, width of CMD_STEPS and the remaining-edge counter.
- PER_W, 16, width of CMD_PERIOD and the edge-spacing timer.
- POS_W, 16, width of POSITION (wraps modulo 2^POS_W).
- INDEX_CLICKS, 24, clicks per revolution for the index feature (4 edges per click).

Ports:
- CLOCK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  block can accept a command.
- CMD_DIR  in  1  1 = count up, 0 = count down.
- CMD_STEPS  in  STEP_W  number of edges to emit.
- CMD_PERIOD  in  PER_W  clocks between edges; 0 is treated as 1.
- ABORT  in  1  terminate the active command.
- A  out  1  quadrature phase A, registered.
- B  out  1  quadrature phase B, registered.
- BUSY  out  1  command in progress.
- DONE  out  1  one-cycle completion pulse.
- POSITION  out  POS_W  signed running edge count.
- INDEX  out  1  once-per-revolution marker (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high):
  - A=0, B=0, phase=0, POSITION=0.
  - BUSY=0, DONE=0, CMD_READY=1, INDEX=0 while asserted.
  - State returns to IDLE.
  - Reset mid-command discards the command; no DONE is generated.
- Phase sequence, up direction, as (A,B): 00 -> 10 -> 11 -> 01 -> 00. Down direction is the reverse. This matches the decoder rule "up when new A differs from previous B".
- State machine: IDLE, RUN, FINISH.
  - IDLE: CMD_READY=1, BUSY=0.
    - On CMD_VALID & CMD_READY, latch DIR, STEPS, and PERIOD (0 becomes 1).
    - If STEPS=0, go to FINISH. Otherwise load timer=PERIOD and go to RUN.
  - RUN: CMD_READY=0, BUSY=1. Timer decrements every clock. When the timer reaches 1:
    - Advance phase one step in DIR and update A/B.
    - POSITION +1 for up, -1 for down, wrapping modulo 2^POS_W.
    - Decrement remaining; reload timer=PERIOD.
    - If remaining reaches 0, go to FINISH.
  - FINISH: DONE=1 for exactly one cycle, BUSY=0, then IDLE. CMD_READY stays 0 in FINISH.
- Latency:
  - First edge appears on A/B exactly PERIOD clocks after the accept edge.
  - Consecutive edges are PERIOD clocks apart.
  - DONE is asserted the cycle after the last edge.
- ABORT:
  - Sampled in RUN only; ignored in IDLE and FINISH.
  - When sampled in RUN, no further edges are emitted and the state goes to FINISH (DONE pulses).
  - If ABORT coincides with a due edge, ABORT wins and no edge is emitted.
- CMD_VALID while not ready is ignored; the command is not queued.
- A and B never change in the same cycle. Exactly one phase bit toggles per edge.
- A/B/POSITION hold their values across commands. A direction reversal between commands is legal.

Optional Feature:
- Macro: QUAD_ENC_INDEX_EN.
- Defined:
  - A revolution counter 0..4*INDEX_CLICKS-1 tracks edges, incrementing on up edges and decrementing on down edges, wrapping at both ends.
  - INDEX=1 while the revolution counter is 0 and A=B=0.
  - Revolution counter resets to 0, so INDEX is 1 after reset deassertion.
- Not defined: INDEX is tied to 0 and no revolution counter is synthesized.

Test Plan:
- Reset then DIR=1, STEPS=4, PERIOD=3 -> edges at +3/+6/+9/+12 clocks after accept. A/B = 10, 11, 01, 00. POSITION=4. DONE pulses at +13. CMD_READY back at +14.
- DIR=0, STEPS=2, PERIOD=0 from POSITION=0 -> A/B = 01 then 11 on consecutive clocks (period clamped to 1). POSITION=0xFFFE.
- STEPS=0, PERIOD=5 -> no A/B change, POSITION unchanged, DONE on the cycle after accept.
- DIR=1, STEPS=100, PERIOD=4; ABORT asserted on the clock the 3rd edge is due -> exactly 2 edges, POSITION=2, DONE next cycle. CMD_VALID held high during RUN is not accepted.
- With QUAD_ENC_INDEX_EN and INDEX_CLICKS=24: DIR=1, STEPS=96, PERIOD=1 -> INDEX=1 at start. INDEX deasserts at the first edge and reasserts only after the 96th edge. The same run in reverse reasserts it likewise.
- Loopback of A/B into the quadrature decoder: DIR=1, STEPS=40, PERIOD=8 -> decoder COUNT=10; then DIR=0, STEPS=40 -> COUNT=0.
